// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter sharing one GMII transmit port between ch0 (ARP) and ch1 (UDP).
// Registers one cycle of latency, enforces the inter-frame gap, and cuts off stalled or overlong sources.
`timescale 1ns/1ps
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 64,
  parameter int MAX_FRAME     = 1530
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic       ch0_req,
  output logic       ch0_gnt,
  input  logic       ch0_tx_en,
  input  logic [7:0] ch0_txd,
  input  logic       ch1_req,
  output logic       ch1_gnt,
  input  logic       ch1_tx_en,
  input  logic [7:0] ch1_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       tmo_err,
  output logic       ovf_err
);

  localparam int CW = $clog2((MAX_FRAME > START_TIMEOUT) ? MAX_FRAME : START_TIMEOUT) + 1;
  localparam logic [CW-1:0] C_TMO_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] C_IFG_LAST = CW'(IFG_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX      = CW'(MAX_FRAME);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_SAT      = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FRAME, S_IFG} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_timer, w_timer_nxt, w_timer_inc;
  logic [CW-1:0] r_len, w_len_nxt, w_len_inc;
  logic          r_owner, w_owner_nxt;
  logic          r_tx_en, w_tx_en_nxt;
  logic          r_tx_er, w_tx_er_nxt;
  logic [7:0]    r_txd, w_txd_nxt;
  logic          r_tmo, w_tmo_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          w_elig0, w_elig1, w_sel_req, w_sel_en, w_granted;
  logic [7:0]    w_sel_txd;

  // r_owner doubles as last_served: it keeps pointing at the most recent grantee after release.
  assign w_sel_req   = r_owner ? ch1_req   : ch0_req;
  assign w_sel_en    = r_owner ? ch1_tx_en : ch0_tx_en;
  assign w_sel_txd   = r_owner ? ch1_txd   : ch0_txd;
  assign w_elig0     = ch0_req & ~ch0_tx_en;
  assign w_elig1     = ch1_req & ~ch1_tx_en;
  assign w_timer_inc = (r_timer == C_SAT) ? r_timer : r_timer + C_ONE;
  assign w_len_inc   = (r_len == C_SAT) ? r_len : r_len + C_ONE;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_len_nxt   = r_len;
    w_owner_nxt = r_owner;
    w_tx_en_nxt = 1'b0;
    w_tx_er_nxt = 1'b0;
    w_txd_nxt   = '0;
    w_tmo_nxt   = 1'b0;
    w_ovf_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_elig0 || w_elig1) begin
          w_owner_nxt = (w_elig0 && w_elig1) ? ~r_owner : w_elig1;
          w_state_nxt = S_WAIT;
          w_timer_nxt = '0;
        end
      end
      S_WAIT: begin
        w_tx_en_nxt = w_sel_en;
        w_txd_nxt   = w_sel_txd;
        if (w_sel_en) begin
          w_state_nxt = S_FRAME;
          w_len_nxt   = C_ONE;
          w_tx_er_nxt = (C_ONE == C_MAX);
        end else if (!w_sel_req) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == C_TMO_LAST) begin
          w_state_nxt = S_IDLE;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      S_FRAME: begin
        // The byte that hit the limit already went out flagged with tx_er; this edge cuts the frame.
        if (r_len == C_MAX) begin
          w_ovf_nxt   = 1'b1;
          w_state_nxt = S_IFG;
          w_timer_nxt = '0;
        end else if (!w_sel_en) begin
          w_state_nxt = S_IFG;
          w_timer_nxt = '0;
        end else begin
          w_tx_en_nxt = 1'b1;
          w_txd_nxt   = w_sel_txd;
          w_len_nxt   = w_len_inc;
          w_tx_er_nxt = (w_len_inc == C_MAX);
        end
      end
      S_IFG: begin
        if (r_timer == C_IFG_LAST) w_state_nxt = S_IDLE;
        else                       w_timer_nxt = w_timer_inc;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_len   <= '0;
      r_owner <= 1'b1;
      r_tx_en <= 1'b0;
      r_tx_er <= 1'b0;
      r_txd   <= '0;
      r_tmo   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_len   <= w_len_nxt;
      r_owner <= w_owner_nxt;
      r_tx_en <= w_tx_en_nxt;
      r_tx_er <= w_tx_er_nxt;
      r_txd   <= w_txd_nxt;
      r_tmo   <= w_tmo_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign w_granted  = (r_state == S_WAIT) || (r_state == S_FRAME);
  assign ch0_gnt    = w_granted & ~r_owner;
  assign ch1_gnt    = w_granted &  r_owner;
  assign gmii_tx_en = r_tx_en;
  assign gmii_tx_er = r_tx_er;
  assign gmii_txd   = r_txd;
  assign busy       = (r_state != S_IDLE);
  assign tmo_err    = r_tmo;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: grant order, data latency, IFG, start timeout, truncation, reset.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;

  logic       gmii_tx_clk = 1'b0;
  logic       rst_n;
  logic       ch0_req, ch0_tx_en, ch1_req, ch1_tx_en;
  logic [7:0] ch0_txd, ch1_txd;
  logic       ch0_gnt, ch1_gnt, gmii_tx_en, gmii_tx_er, busy, tmo_err, ovf_err;
  logic [7:0] gmii_txd;

  int errors = 0;
  int checks = 0;

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  gmii_tx_arbiter dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .ch0_req     (ch0_req),
    .ch0_gnt     (ch0_gnt),
    .ch0_tx_en   (ch0_tx_en),
    .ch0_txd     (ch0_txd),
    .ch1_req     (ch1_req),
    .ch1_gnt     (ch1_gnt),
    .ch1_tx_en   (ch1_tx_en),
    .ch1_txd     (ch1_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .gmii_txd    (gmii_txd),
    .busy        (busy),
    .tmo_err     (tmo_err),
    .ovf_err     (ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge gmii_tx_clk);
  endtask

  task automatic drive(input int ch, input logic en, input logic [7:0] d);
    if (ch == 0) begin ch0_tx_en = en; ch0_txd = d; end
    else         begin ch1_tx_en = en; ch1_txd = d; end
  endtask

  task automatic set_req(input int ch, input logic v);
    if (ch == 0) ch0_req = v;
    else         ch1_req = v;
  endtask

  function automatic logic gnt_of(input int ch);
    return (ch == 0) ? ch0_gnt : ch1_gnt;
  endfunction

  task automatic check_quiet(input string tag);
    check(tag, 32'({gmii_tx_en, gmii_tx_er, gmii_txd, ch0_gnt, ch1_gnt, busy, tmo_err, ovf_err}), 32'(0));
  endtask

  task automatic wait_gnt(input int ch, input int bound, output int cycles);
    cycles = 0;
    while (gnt_of(ch) !== 1'b1 && cycles < bound) begin
      step(1);
      cycles++;
    end
    check((ch == 0) ? "gnt0" : "gnt1", 32'(gnt_of(ch)), 32'(1));
  endtask

  // Drives len bytes; each appears on the output one cycle later with the grant still held.
  task automatic send_frame(input int ch, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      drive(ch, 1'b1, base + 8'(i));
      step(1);
      check("frame_byte", 32'({gnt_of(ch), gmii_tx_er, gmii_tx_en, gmii_txd}),
            32'({1'b1, 1'b0, 1'b1, base + 8'(i)}));
    end
    drive(ch, 1'b0, 8'h00);
    set_req(ch, 1'b0);
    step(1);
    check("eof_gnt_en", 32'({gnt_of(ch), gmii_tx_en}), 32'(0));
  endtask

  always @(negedge gmii_tx_clk)
    if (rst_n === 1'b1) check("exclusive_gnt", 32'(ch0_gnt & ch1_gnt), 32'(0));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, nbytes, ndata, ner, er_at, novf, ovf_at, regrant;
    rst_n = 1'b0;
    ch0_req = 1'b0; ch1_req = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    step(3);
    check_quiet("reset_outputs");

    // T1: lone ch0 request, 64-byte frame two cycles after grant.
    rst_n = 1'b1;
    set_req(0, 1'b1);
    wait_gnt(0, 4, c);
    check("t1_gnt_latency", 32'(c), 32'(1));
    check("t1_busy", 32'(busy), 32'(1));
    step(1);
    check("t1_pre_frame_en", 32'(gmii_tx_en), 32'(0));
    send_frame(0, 64, 8'h01);
    check("t1_busy_ifg", 32'(busy), 32'(1));
    step(11);
    check("t1_busy_ifg_end", 32'(busy), 32'(1));
    step(1);
    check("t1_busy_idle", 32'(busy), 32'(0));

    // T2: simultaneous requests after reset, served ch0 then ch1, twice.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    set_req(0, 1'b1); set_req(1, 1'b1);
    wait_gnt(0, 4, c);
    check("t2_ch1_waits", 32'(ch1_gnt), 32'(0));
    send_frame(0, 8, 8'h10);
    wait_gnt(1, 40, c);
    check("t2_gap_ge_14", 32'(c + 1 >= 14), 32'(1));
    send_frame(1, 8, 8'h20);
    set_req(0, 1'b1); set_req(1, 1'b1);
    wait_gnt(0, 40, c);
    check("t2_repeat_ch1_waits", 32'(ch1_gnt), 32'(0));
    send_frame(0, 5, 8'h30);
    wait_gnt(1, 40, c);
    check("t2_repeat_gap_ge_14", 32'(c + 1 >= 14), 32'(1));
    send_frame(1, 5, 8'h38);

    // T3: ch1 granted but never starts; times out after 64 cycles, then ch0 wins.
    set_req(1, 1'b1);
    wait_gnt(1, 40, c);
    set_req(0, 1'b1);
    step(63);
    check("t3_before_tmo", 32'({ch1_gnt, tmo_err}), 32'(2'b10));
    step(1);
    check("t3_tmo", 32'({ch1_gnt, tmo_err, busy}), 32'(3'b010));
    step(1);
    check("t3_ch0_next", 32'({ch0_gnt, ch1_gnt, tmo_err}), 32'(3'b100));

    // T5: ch0 withdraws 3 cycles after grant; no IFG, ch1 follows at once.
    step(3);
    set_req(0, 1'b0);
    step(1);
    check("t5_cancel", 32'({ch0_gnt, busy, tmo_err}), 32'(0));
    step(1);
    check("t5_ch1_gnt", 32'({ch0_gnt, ch1_gnt}), 32'(2'b01));
    send_frame(1, 4, 8'h40);

    // T4: ch0 streams 1600 cycles; only 1530 bytes pass, the last flagged with tx_er.
    set_req(0, 1'b1);
    wait_gnt(0, 40, c);
    nbytes = 0; ndata = 0; ner = 0; er_at = 0; novf = 0; ovf_at = 0; regrant = 0;
    for (int i = 0; i < 1600; i++) begin
      drive(0, 1'b1, 8'(i));
      step(1);
      if (gmii_tx_en) begin
        nbytes++;
        if (gmii_txd !== 8'(nbytes - 1)) ndata++;
      end
      if (gmii_tx_er) begin ner++; er_at = nbytes; end
      if (ovf_err) begin novf++; ovf_at = nbytes; end
      if (novf > 0 && ch0_gnt) regrant++;
    end
    check("t4_byte_count", 32'(nbytes), 32'(1530));
    check("t4_data_errors", 32'(ndata), 32'(0));
    check("t4_er_count", 32'(ner), 32'(1));
    check("t4_er_position", 32'(er_at), 32'(1530));
    check("t4_ovf_count", 32'(novf), 32'(1));
    check("t4_ovf_position", 32'(ovf_at), 32'(1530));
    check("t4_no_regrant", 32'(regrant), 32'(0));
    drive(0, 1'b0, 8'h00);
    step(1);
    check("t4_regrant_after_fall", 32'(ch0_gnt), 32'(1));
    set_req(0, 1'b0);
    step(1);
    check("t4_cancel", 32'(ch0_gnt), 32'(0));

    // T6: reset in the middle of a ch0 frame, then a tie must go to ch0 again.
    set_req(0, 1'b1);
    wait_gnt(0, 10, c);
    for (int i = 0; i < 19; i++) begin
      drive(0, 1'b1, 8'h80 + 8'(i));
      step(1);
    end
    check("t6_in_frame", 32'({gmii_tx_en, gmii_txd}), 32'({1'b1, 8'h92}));
    drive(0, 1'b1, 8'h93);
    rst_n = 1'b0;
    step(1);
    check_quiet("t6_reset_outputs");
    rst_n = 1'b1;
    drive(0, 1'b0, 8'h00);
    set_req(1, 1'b1);
    step(1);
    check("t6_tie_to_ch0", 32'({ch0_gnt, ch1_gnt}), 32'(2'b10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
